pool_feature_buffer: RTL and testbench
======================================

# pool_feature_buffer

Double-buffered collector directly downstream of the pooling layer. It captures the pooled words produced one at a time by the pooling output interface, each tagged with feature index and pooled row. It assembles one complete pooled frame (all features × rows × columns) per bank, then streams the frame to the next layer (fully-connected input) over a valid/ready handshake while the other bank fills.

## Interface
- DATA_WIDTH, 32, word width (IEEE-754 single, opaque to this block)
- FEATURE_NUM, 4, feature maps per frame
- OUT_ROWS, 3, pooled rows per feature
- OUT_COLS, 3, pooled columns per row
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  pooled word present this cycle; no backpressure upstream
- in_feature  input  2  feature index of the word
- in_row  input  3  pooled row of the word (0..OUT_ROWS-1)
- in_data  input  DATA_WIDTH  pooled word
- out_valid  output  1  out_data/tags valid
- out_ready  input  1  consumer accepts word when out_valid & out_ready
- out_data  output  DATA_WIDTH  streamed word
- out_last  output  1  final word of frame
- overflow  output  1  sticky: a word was dropped because both banks were full

## Operation
- FRAME = FEATURE_NUM·OUT_ROWS·OUT_COLS (36 by default); two banks of FRAME words.
- Write side: wr_bank register, col counter (0..OUT_COLS-1), word counter wr_cnt (0..FRAME-1).
  - Accepted word written at feature·OUT_ROWS·OUT_COLS + row·OUT_COLS + col; col increments, wraps to 0 after OUT_COLS-1.
  - When wr_cnt reaches FRAME-1 on an accepted word: full[wr_bank] set, wr_bank toggles, wr_cnt and col clear.
  - in_valid while full[wr_bank] set: word dropped, counters unchanged, overflow set (cleared only by reset).
  - in_row ≥ OUT_ROWS or in_feature ≥ FEATURE_NUM: word dropped, overflow set.
- Read side FSM, rd_bank register:
  - IDLE: when full[rd_bank] → LOAD, issue read of address 0.
  - LOAD: memory data returns; out_valid rises → STREAM.
  - STREAM: on handshake, advance address; prefetch so a new word is presented every cycle out_ready is high. On handshake of address FRAME-1 (out_last=1): clear full[rd_bank], toggle rd_bank, → IDLE.
- Output order: feature-major, then row, then column.
- Same-cycle full-set by writer and full-clear by reader on different banks: both take effect.

## Timing
- Reset: out_valid 0, out_data 0, out_last 0, overflow 0, wr_bank/rd_bank 0, counters 0, full flags 0, FSM IDLE.
- Write: word stored at the in_valid edge; bank readable the cycle after its last word is written.
- Latency: last input word at edge N → out_valid high after edge N+2 (IDLE→LOAD at N+1, data registered at N+2).
- Throughput: one word/cycle each side; full frame drains in FRAME cycles with out_ready held high.
- out_data/out_last held stable while out_valid & !out_ready.
- Reset mid-frame discards both banks; no partial frame is ever emitted.

## Configuration
- POOL_FEATURE_BUFFER_RELU_EN defined: out_data forced to 0 when the word's sign bit (DATA_WIDTH-1) is 1; ReLU applied at the output register, no extra latency.
- Not defined: out_data passes stored word unchanged.

## Structure
- Shared package pooling_pkg: DATA_WIDTH, FEATURE_NUM, OUT_ROWS, OUT_COLS, FRAME, address width, read-FSM state enum.
- One sub-module: pool_buf_bank — 1-write/1-read synchronous RAM, registered read, instantiated twice (or once at 2·FRAME depth, bank as address MSB).

## Test plan
- Single frame: 36 words in order, data = 0x3F800000+index, out_ready=1 → 36 outputs in same order from 2 cycles after last input, out_last only on word 35.
- Out-of-order rows: feature 1 rows sent 2,0,1 → output still row 0,1,2 for feature 1.
- Backpressure: out_ready toggled 1,0,0,1 during stream → no lost/duplicated words, out_data stable while stalled.
- Overflow: 3 frames input back-to-back with out_ready=0 → first two frames buffered, all 36 words of the third dropped, overflow=1, then the two buffered frames drain intact.
- ReLU with macro: word 0xC0000000 → 0x00000000; without macro → 0xC0000000.
- Reset after 20 words of a frame → out_valid stays 0; fresh 36-word frame afterwards streams correctly.

Source files
------------

// File: rtl/pooling_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pooling_pkg
//  Description : Shared constants, types and helpers for the pooled-feature
//                frame buffer: frame geometry, address widths and the
//                read-side FSM state encoding.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package pooling_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int FEATURE_NUM = 4;
    localparam int OUT_ROWS    = 3;
    localparam int OUT_COLS    = 3;
    localparam int FRAME       = FEATURE_NUM * OUT_ROWS * OUT_COLS;

    localparam int FEAT_W      = 2;
    localparam int ROW_W       = 3;
    localparam int COL_W       = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;

    // One spare code so the read prefetch pointer can sit at FRAME.
    localparam int ADDR_W      = $clog2(FRAME + 1);

    // Both banks live in a single RAM, bank b occupying [b*FRAME, b*FRAME+FRAME).
    localparam int RAM_DEPTH   = 2 * FRAME;
    localparam int RAM_AW      = $clog2(RAM_DEPTH);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(OUT_COLS - 1);

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_LOAD   = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_t;

    // Physical RAM address of word 'offset' within bank 'bank'.
    function automatic logic [RAM_AW-1:0] ram_addr(input logic bank, input int offset);
        return RAM_AW'(int'(bank) * FRAME + offset);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pool_feature_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pool_feature_buffer_if
//  Description : Bundles the pooled-word input port and the streaming output
//                handshake of the pooled feature buffer.
//  Signals     : in_valid/in_feature/in_row/in_data  - pooled word from pool
//                out_valid/out_ready/out_data/out_last - stream to next layer
//                overflow                              - sticky drop flag
//  Modports    : slave  - buffer side
//                master - producer/consumer (environment) side
//  Revision    : 1.0 - initial release
// ============================================================================
interface pool_feature_buffer_if;
    import pooling_pkg::*;

    logic                  in_valid;
    logic [FEAT_W-1:0]     in_feature;
    logic [ROW_W-1:0]      in_row;
    logic [DATA_WIDTH-1:0] in_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    logic                  overflow;

    modport slave (
        input  in_valid, in_feature, in_row, in_data, out_ready,
        output out_valid, out_data, out_last, overflow
    );

    modport master (
        output in_valid, in_feature, in_row, in_data, out_ready,
        input  out_valid, out_data, out_last, overflow
    );

endinterface
`default_nettype wire

// File: rtl/pool_buf_bank.sv
`default_nettype none
// ============================================================================
//  Module      : pool_buf_bank
//  Description : Simple dual-port synchronous RAM, one write and one read
//                port, registered read data (one-cycle read latency). Read
//                data holds its value on cycles without a read enable.
//  Ports       : clk            - clock
//                we/waddr/wdata - write port
//                re/raddr       - read request
//                rdata          - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_buf_bank
    import pooling_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int DEPTH = RAM_DEPTH,
    parameter int AW    = RAM_AW
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/pool_feature_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : pool_feature_buffer
//  Description : Double-buffered collector behind the pooling layer. Pooled
//                words tagged with feature/row are assembled into a full
//                frame in one bank while the other bank streams out,
//                feature-major / row / column, over a valid/ready handshake.
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - pool_feature_buffer_if.slave (input words, output
//                        stream, sticky overflow)
//  Config      : POOL_FEATURE_BUFFER_RELU_EN - when defined, words with the
//                sign bit set leave as zero (ReLU on the output register).
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_feature_buffer
    import pooling_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    pool_feature_buffer_if.slave bus
);

    // ------------------------------------------------------------------
    // Output word transform
    // ------------------------------------------------------------------
    function automatic logic [DATA_WIDTH-1:0] out_word(input logic [DATA_WIDTH-1:0] w);
`ifdef POOL_FEATURE_BUFFER_RELU_EN
        return w[DATA_WIDTH-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic                  r_wr_bank;
    logic [COL_W-1:0]      r_col;
    logic [ADDR_W-1:0]     r_wr_cnt;
    logic [1:0]            r_full;
    logic [1:0]            w_full_next;
    logic                  r_overflow;

    logic                  w_tags_ok;
    logic                  w_accept;
    logic                  w_drop;
    logic                  w_frame_done;
    logic [RAM_AW-1:0]     w_waddr;

    // Read side signals used by the shared full-flag logic
    logic                  r_rd_bank;
    logic                  w_rd_done;

    assign w_tags_ok    = (32'(bus.in_feature) < 32'(FEATURE_NUM)) &&
                          (32'(bus.in_row)     < 32'(OUT_ROWS));
    assign w_accept     = bus.in_valid && w_tags_ok && !r_full[r_wr_bank];
    assign w_drop       = bus.in_valid && !w_accept;
    assign w_frame_done = w_accept && (r_wr_cnt == LAST_ADDR);

    // Column comes from the running counter, not the input tags: words of a
    // row arrive in column order, rows/features may arrive in any order.
    assign w_waddr = ram_addr(r_wr_bank,
                              int'(bus.in_feature) * (OUT_ROWS * OUT_COLS) +
                              int'(bus.in_row) * OUT_COLS +
                              int'(r_col));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bank  <= 1'b0;
            r_col      <= '0;
            r_wr_cnt   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_accept) begin
                if (w_frame_done) begin
                    r_wr_cnt  <= '0;
                    r_col     <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
                    r_col    <= (r_col == LAST_COL) ? '0 : r_col + COL_W'(1);
                end
            end
        end
    end

    // Writer and reader always work on different banks when both touch the
    // flags in one cycle, so set and clear can both be applied.
    always_comb begin
        w_full_next = r_full;
        if (w_frame_done) begin
            w_full_next[r_wr_bank] = 1'b1;
        end
        if (w_rd_done) begin
            w_full_next[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= '0;
        end else begin
            r_full <= w_full_next;
        end
    end

    // ------------------------------------------------------------------
    // Frame storage
    // ------------------------------------------------------------------
    logic                  w_ram_re;
    logic [ADDR_W-1:0]     w_rd_idx;
    logic [RAM_AW-1:0]     w_raddr;
    logic [DATA_WIDTH-1:0] w_ram_rdata;

    assign w_raddr = ram_addr(r_rd_bank, int'(w_rd_idx));

    pool_buf_bank #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RAM_DEPTH),
        .AW    (RAM_AW)
    ) u_bank (
        .clk   (clk),
        .we    (w_accept),
        .waddr (w_waddr),
        .wdata (bus.in_data),
        .re    (w_ram_re),
        .raddr (w_raddr),
        .rdata (w_ram_rdata)
    );

    // ------------------------------------------------------------------
    // Read side
    //
    // Two-stage pipeline: RAM read register holds word k+1 while the output
    // register presents word k. A read is only issued when the output
    // register advances, so a stalled consumer freezes both stages.
    // r_rd_addr is the next word to fetch into the RAM read register.
    // ------------------------------------------------------------------
    rd_state_t             r_state;
    rd_state_t             w_state_next;
    logic [ADDR_W-1:0]     r_rd_addr;
    logic [ADDR_W-1:0]     w_rd_addr_next;
    logic [ADDR_W-1:0]     r_out_idx;
    logic [ADDR_W-1:0]     w_out_idx_next;
    logic                  w_load_out;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_ram_re       = 1'b0;
        w_rd_idx       = '0;
        w_rd_addr_next = r_rd_addr;
        w_load_out     = 1'b0;
        w_rd_done      = 1'b0;

        unique case (r_state)
            RD_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_ram_re       = 1'b1;
                    w_rd_idx       = '0;
                    w_rd_addr_next = ADDR_W'(1);
                    w_state_next   = RD_LOAD;
                end
            end

            RD_LOAD: begin
                // Word 0 is in the RAM register; move it out and prefetch 1.
                w_load_out   = 1'b1;
                w_state_next = RD_STREAM;
                if (r_rd_addr <= LAST_ADDR) begin
                    w_ram_re       = 1'b1;
                    w_rd_idx       = r_rd_addr;
                    w_rd_addr_next = r_rd_addr + ADDR_W'(1);
                end
            end

            RD_STREAM: begin
                // out_valid is always high in this state.
                if (bus.out_ready) begin
                    if (r_out_idx == LAST_ADDR) begin
                        w_rd_done    = 1'b1;
                        w_state_next = RD_IDLE;
                    end else begin
                        w_load_out = 1'b1;
                        if (r_rd_addr <= LAST_ADDR) begin
                            w_ram_re       = 1'b1;
                            w_rd_idx       = r_rd_addr;
                            w_rd_addr_next = r_rd_addr + ADDR_W'(1);
                        end
                    end
                end
            end

            default: begin
                w_state_next = RD_IDLE;
            end
        endcase
    end

    assign w_out_idx_next = (r_state == RD_LOAD) ? '0 : r_out_idx + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_bank   <= 1'b0;
            r_rd_addr   <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_rd_addr <= w_rd_addr_next;
            if (w_load_out) begin
                r_out_valid <= 1'b1;
                r_out_data  <= out_word(w_ram_rdata);
                r_out_last  <= (w_out_idx_next == LAST_ADDR);
                r_out_idx   <= w_out_idx_next;
            end else if (w_rd_done) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
            if (w_rd_done) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pool_feature_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pool_feature_buffer
//  Description : Self-checking bench for pool_feature_buffer. A frame-level
//                reference model collects accepted words into a frame image
//                and queues the whole frame in output order once complete.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_feature_buffer;

    localparam int FRAME = 36;
    localparam int FEATS = 4;
    localparam int ROWS  = 3;
    localparam int COLS  = 3;
    localparam int FSZ   = ROWS * COLS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int tests = 0;
    int fails = 0;

    pool_feature_buffer_if bus();

    pool_feature_buffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] relu_ref(input logic [31:0] w);
`ifdef POOL_FEATURE_BUFFER_RELU_EN
        return w[31] ? 32'h0 : w;
`else
        return w;
`endif
    endfunction

    // ------------------------------------------------------------------
    // Reference model and output monitor
    // ------------------------------------------------------------------
    logic [31:0] m_fill [FRAME];
    int          m_cnt     = 0;
    int          m_col     = 0;
    int          m_held    = 0;
    int          m_out_cnt = 0;
    bit          m_ovf     = 1'b0;
    logic [32:0] exp_q [$];
    logic [32:0] obs_q [$];

    int          stall_err  = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_cnt = 0; m_col = 0; m_held = 0; m_out_cnt = 0; m_ovf = 1'b0;
                exp_q.delete();
                obs_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data ||
                                   bus.out_last !== prev_last)) begin
                    stall_err++;
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
                prev_last  = bus.out_last;

                if (bus.in_valid) begin
                    if (int'(bus.in_feature) >= FEATS || int'(bus.in_row) >= ROWS || m_held == 2) begin
                        m_ovf = 1'b1;
                    end else begin
                        m_fill[int'(bus.in_feature) * FSZ + int'(bus.in_row) * COLS + m_col] = bus.in_data;
                        m_col = (m_col + 1) % COLS;
                        m_cnt++;
                        if (m_cnt == FRAME) begin
                            for (int i = 0; i < FRAME; i++) begin
                                exp_q.push_back({(i == FRAME - 1), relu_ref(m_fill[i])});
                            end
                            m_held++;
                            m_cnt = 0;
                            m_col = 0;
                        end
                    end
                end

                if (bus.out_valid && bus.out_ready) begin
                    obs_q.push_back({bus.out_last, bus.out_data});
                    m_out_cnt++;
                    if (m_out_cnt == FRAME) begin
                        m_out_cnt = 0;
                        m_held--;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive_word(input int f, input int r, input logic [31:0] d);
        bus.in_valid   = 1'b1;
        bus.in_feature = 2'(f);
        bus.in_row     = 3'(r);
        bus.in_data    = d;
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        bus.out_ready = 1'b1;
        while (obs_q.size() < exp_q.size() && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        idle(4);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_feature = '0; bus.in_row = '0; bus.in_data = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2);
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        tests++; if (bus.out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data: got %h expected 00000000", bus.out_data); end
        tests++; if (bus.out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last: got %b expected 0", bus.out_last); end
        tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
    endtask

    task automatic test_single_frame();
        logic [32:0] e;
        exp_q.delete(); obs_q.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < FRAME; i++) drive_word(i / FSZ, (i / COLS) % ROWS, 32'h3F800000 + 32'(i));
        @(posedge clk); #1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL latency_n1: out_valid got %b expected 0", bus.out_valid); end
        @(posedge clk); #1;
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h3F800000 || bus.out_last !== 1'b0) begin
            fails++;
            $display("FAIL latency_n2: got v=%b d=%h l=%b expected v=1 d=3f800000 l=0", bus.out_valid, bus.out_data, bus.out_last);
        end
        drain(200);
        tests++; if (obs_q.size() != FRAME) begin fails++; $display("FAIL single_count: got %0d expected %0d", obs_q.size(), FRAME); end
        for (int i = 0; i < obs_q.size() && i < FRAME; i++) begin
            e = {(i == FRAME - 1), 32'h3F800000 + 32'(i)};
            tests++; if (obs_q[i] !== e) begin fails++; $display("FAIL single_word%0d: got %h expected %h", i, obs_q[i], e); end
        end
    endtask

    task automatic test_ooo_rows();
        logic [31:0] sent [FEATS][ROWS][COLS];
        int order [3];
        int j, t;
        logic [32:0] e;
        exp_q.delete(); obs_q.delete();
        for (int f = 0; f < FEATS; f++) begin
            if (f == 1) begin
                order[0] = 2; order[1] = 0; order[2] = 1;
            end else begin
                order[0] = 0; order[1] = 1; order[2] = 2;
                j = $urandom_range(0, 2); t = order[0]; order[0] = order[j]; order[j] = t;
                j = $urandom_range(1, 2); t = order[1]; order[1] = order[j]; order[j] = t;
            end
            for (int k = 0; k < ROWS; k++) begin
                for (int c = 0; c < COLS; c++) begin
                    sent[f][order[k]][c] = $urandom;
                    bus.out_ready = 1'($urandom_range(0, 1));
                    drive_word(f, order[k], sent[f][order[k]][c]);
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
            end
        end
        drain(300);
        tests++; if (obs_q.size() != FRAME) begin fails++; $display("FAIL ooo_count: got %0d expected %0d", obs_q.size(), FRAME); end
        for (int i = 0; i < obs_q.size() && i < FRAME; i++) begin
            e = {(i == FRAME - 1), relu_ref(sent[i / FSZ][(i / COLS) % ROWS][i % COLS])};
            tests++; if (obs_q[i] !== e) begin fails++; $display("FAIL ooo_word%0d: got %h expected %h", i, obs_q[i], e); end
        end
    endtask

    task automatic test_backpressure();
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] sent [FRAME];
        logic [32:0] e;
        int err0;
        int n = 0;
        exp_q.delete(); obs_q.delete();
        err0 = stall_err;
        bus.out_ready = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            sent[i] = $urandom;
            drive_word(i / FSZ, (i / COLS) % ROWS, sent[i]);
        end
        while (obs_q.size() < FRAME && n < 400) begin
            bus.out_ready = pat[n % 4];
            @(posedge clk); #1;
            n++;
        end
        bus.out_ready = 1'b1;
        idle(4);
        tests++; if (stall_err != err0) begin fails++; $display("FAIL bp_stable: got %0d stall changes expected 0", stall_err - err0); end
        tests++; if (obs_q.size() != FRAME) begin fails++; $display("FAIL bp_count: got %0d expected %0d", obs_q.size(), FRAME); end
        for (int i = 0; i < obs_q.size() && i < FRAME; i++) begin
            e = {(i == FRAME - 1), relu_ref(sent[i])};
            tests++; if (obs_q[i] !== e) begin fails++; $display("FAIL bp_word%0d: got %h expected %h", i, obs_q[i], e); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] sent [2*FRAME];
        logic [31:0] d;
        logic [32:0] e;
        exp_q.delete(); obs_q.delete();
        bus.out_ready = 1'b0;
        for (int fr = 0; fr < 3; fr++) begin
            for (int i = 0; i < FRAME; i++) begin
                d = $urandom;
                if (fr < 2) sent[fr * FRAME + i] = d;
                drive_word(i / FSZ, (i / COLS) % ROWS, d);
            end
        end
        tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b expected 1", bus.overflow); end
        idle(2);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== relu_ref(sent[0])) begin
            fails++;
            $display("FAIL ovf_head: got v=%b d=%h expected v=1 d=%h", bus.out_valid, bus.out_data, relu_ref(sent[0]));
        end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL ovf_no_accept: got %0d words expected 0", obs_q.size()); end
        drain(400);
        tests++; if (obs_q.size() != 2 * FRAME) begin fails++; $display("FAIL ovf_count: got %0d expected %0d", obs_q.size(), 2 * FRAME); end
        for (int i = 0; i < obs_q.size() && i < 2 * FRAME; i++) begin
            e = {((i % FRAME) == FRAME - 1), relu_ref(sent[i])};
            tests++; if (obs_q[i] !== e) begin fails++; $display("FAIL ovf_word%0d: got %h expected %h", i, obs_q[i], e); end
        end
        tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b expected 1", bus.overflow); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] sent [FRAME];
        logic [32:0] e;
        bit seen = 1'b0;
        exp_q.delete(); obs_q.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) drive_word(i / FSZ, (i / COLS) % ROWS, $urandom);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL rst_mid_ovf: got %b expected 0", bus.overflow); end
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        tests++; if (seen) begin fails++; $display("FAIL rst_mid_no_output: got out_valid 1 expected 0"); end
        for (int i = 0; i < FRAME; i++) begin
            sent[i] = $urandom;
            drive_word(i / FSZ, (i / COLS) % ROWS, sent[i]);
        end
        drain(200);
        tests++; if (obs_q.size() != FRAME) begin fails++; $display("FAIL rst_mid_count: got %0d expected %0d", obs_q.size(), FRAME); end
        for (int i = 0; i < obs_q.size() && i < FRAME; i++) begin
            e = {(i == FRAME - 1), relu_ref(sent[i])};
            tests++; if (obs_q[i] !== e) begin fails++; $display("FAIL rst_mid_word%0d: got %h expected %h", i, obs_q[i], e); end
        end
    endtask

    task automatic test_invalid_tags();
        logic [31:0] sent [FRAME];
        logic [32:0] e;
        exp_q.delete(); obs_q.delete();
        bus.out_ready = 1'b1;
        drive_word($urandom_range(0, 3), 3 + $urandom_range(0, 4), $urandom);
        tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL badrow_ovf: got %b expected 1", bus.overflow); end
        idle(3);
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL badrow_no_output: got %b expected 0", bus.out_valid); end
        for (int i = 0; i < FRAME; i++) begin
            sent[i] = $urandom;
            drive_word(i / FSZ, (i / COLS) % ROWS, sent[i]);
        end
        drain(200);
        tests++; if (obs_q.size() != FRAME) begin fails++; $display("FAIL badrow_count: got %0d expected %0d", obs_q.size(), FRAME); end
        for (int i = 0; i < obs_q.size() && i < FRAME; i++) begin
            e = {(i == FRAME - 1), relu_ref(sent[i])};
            tests++; if (obs_q[i] !== e) begin fails++; $display("FAIL badrow_word%0d: got %h expected %h", i, obs_q[i], e); end
        end
    endtask

    task automatic test_relu();
        logic [31:0] d;
        logic [31:0] want0;
`ifdef POOL_FEATURE_BUFFER_RELU_EN
        want0 = 32'h00000000;
`else
        want0 = 32'hC0000000;
`endif
        exp_q.delete(); obs_q.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            d = (i == 0) ? 32'hC0000000 : $urandom;
            drive_word(i / FSZ, (i / COLS) % ROWS, d);
        end
        drain(200);
        tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL relu_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        if (obs_q.size() > 0) begin
            tests++; if (obs_q[0][31:0] !== want0) begin fails++; $display("FAIL relu_word0: got %h expected %h", obs_q[0][31:0], want0); end
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL relu_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        for (int fr = 0; fr < 4; fr++) begin
            for (int i = 0; i < FRAME; i++) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                drive_word(i / FSZ, (i / COLS) % ROWS, $urandom);
            end
        end
        drain(800);
        tests++; if (bus.overflow !== m_ovf) begin fails++; $display("FAIL b2b_ovf: got %b expected %b", bus.overflow, m_ovf); end
        tests++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL b2b_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL b2b_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    // ------------------------------------------------------------------
    // Sequencer and watchdog
    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_single_frame();
        test_ooo_rows();
        test_backpressure();
        test_overflow();
        test_reset_mid_frame();
        test_invalid_tags();
        test_relu();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
